// File: rtl/thor2023_cache_hit_unit_if.sv
// Lookup/fill/invalidate/snoop bundle for one Thor2023 I-cache tag bank.
// The master side drives requests; the slave side returns hit, way and registered hit.
interface thor2023_cache_hit_unit_if #(
    parameter int unsigned AWID  = 32,
    parameter int unsigned LINES = 128,
    parameter int unsigned WAYS  = 4
);
    localparam int unsigned WayW = $clog2(WAYS);
    localparam int unsigned IdxW = $clog2(LINES);

    logic            wr;
    logic [WayW-1:0] way;
    logic [AWID-1:0] vadr_i;
    logic [AWID-1:0] padr_i;
    logic [AWID-1:0] adr;
    logic [IdxW-1:0] ndx;
    logic            inv;
    logic            invline;
    logic            invall;
    logic            snoop_v;
    logic [AWID-1:0] snoop_adr;
    logic            hit;
    logic [WayW-1:0] rway;
    logic            cv;

    modport master (
        output wr, way, vadr_i, padr_i, adr, ndx, inv, invline, invall, snoop_v, snoop_adr,
        input  hit, rway, cv
    );

    modport slave (
        input  wr, way, vadr_i, padr_i, adr, ndx, inv, invline, invall, snoop_v, snoop_adr,
        output hit, rway, cv
    );
endinterface

// File: rtl/thor2023_cache_hit_unit.sv
// Per-bank tag store and same-cycle hit detector for the Thor2023 instruction cache.
// Tags are never reset; the valid bits alone decide whether an entry can match.
module thor2023_cache_hit_unit #(
    parameter int unsigned AWID   = 32,
    parameter int unsigned LINES  = 128,
    parameter int unsigned WAYS   = 4,
    parameter int unsigned LOBIT  = 6,
    parameter int unsigned HIBIT  = $clog2(LINES) - 1 + LOBIT,
    parameter int unsigned TAGBIT = HIBIT + 2
) (
    input logic                      clk,
    input logic                      rst,
    thor2023_cache_hit_unit_if.slave bus
);
    localparam int unsigned WayW = $clog2(WAYS);
    localparam int unsigned TagW = AWID - TAGBIT;

    logic [TagW-1:0]              vtag_q [WAYS][LINES];
    logic [TagW-1:0]              ptag_q [WAYS][LINES];
    logic [WAYS-1:0][LINES-1:0]   valid_q, valid_d;
    logic                         cv_q;

    logic [HIBIT-LOBIT:0] widx, sidx;
    logic [TagW-1:0]      wvtag, wptag, stag, ltag;
    logic [WAYS-1:0]      match, snp_hit;
    logic                 hit_c;
    logic [WayW-1:0]      rway_c;

    assign widx  = bus.vadr_i[HIBIT:LOBIT];
    assign sidx  = bus.snoop_adr[HIBIT:LOBIT];
    assign wvtag = bus.vadr_i[AWID-1:TAGBIT];
    assign wptag = bus.padr_i[AWID-1:TAGBIT];
    assign stag  = bus.snoop_adr[AWID-1:TAGBIT];
    assign ltag  = bus.adr[AWID-1:TAGBIT];

    // Offset and bank-select bits play no part in the tag store.
    logic unused_bits;
    assign unused_bits = ^{bus.adr[TAGBIT-1:0], bus.padr_i[TAGBIT-1:0],
                           bus.vadr_i[LOBIT-1:0], bus.vadr_i[TAGBIT-1:HIBIT+1],
                           bus.snoop_adr[LOBIT-1:0], bus.snoop_adr[TAGBIT-1:HIBIT+1]};

    // Descending scan so the lowest matching way wins.
    always_comb begin
        match  = '0;
        rway_c = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            match[w] = valid_q[w][bus.ndx] && (vtag_q[w][bus.ndx] == ltag);
            if (match[w]) rway_c = WayW'(w);
        end
        hit_c = |match;
    end

    // A snoop is compared against the ptag the entry will hold after this edge.
    always_comb begin
        snp_hit = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (bus.wr && bus.way == WayW'(w) && widx == sidx) snp_hit[w] = (wptag == stag);
            else snp_hit[w] = (ptag_q[w][sidx] == stag);
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (bus.inv) begin
            if (bus.invline) begin
                for (int w = 0; w < int'(WAYS); w++) valid_d[w][widx] = 1'b0;
            end else if (bus.invall) begin
                valid_d = '0;
            end
        end
        if (bus.wr) valid_d[bus.way][widx] = 1'b1;
        if (bus.snoop_v) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                if (snp_hit[w]) valid_d[w][sidx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            cv_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            cv_q    <= hit_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && bus.wr) begin
            vtag_q[bus.way][widx] <= wvtag;
            ptag_q[bus.way][widx] <= wptag;
        end
    end

    assign bus.hit  = hit_c;
    assign bus.rway = rway_c;
    assign bus.cv   = cv_q;
endmodule

// File: tb/tb_thor2023_cache_hit_unit.sv
// Self-checking bench for thor2023_cache_hit_unit: directed scenarios plus a random run
// checked against a behavioural tag/valid model.
module tb_thor2023_cache_hit_unit;
    localparam logic [31:0] A = 32'h0001_2140;
    localparam logic [31:0] P = 32'h8001_2140;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    thor2023_cache_hit_unit_if #(.AWID(32), .LINES(128), .WAYS(4)) bus ();

    thor2023_cache_hit_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    bit         m_valid [4][128];
    logic [17:0] m_vtag [4][128];
    logic [17:0] m_ptag [4][128];

    logic       obs_hit, obs_cv, exp_hit, exp_cv;
    logic [1:0] obs_rway, exp_rway;

    function automatic logic [31:0] mk(input int tag, input int line);
        mk = (32'(tag) << 14) | (32'(line) << 6);
    endfunction

    task automatic model_lookup(input logic [31:0] a, input logic [6:0] n,
                                output logic h, output logic [1:0] rw);
        h  = 1'b0;
        rw = 2'd0;
        for (int w = 0; w < 4; w++) begin
            if (!h && m_valid[w][n] && m_vtag[w][n] == a[31:14]) begin
                h  = 1'b1;
                rw = 2'(w);
            end
        end
    endtask

    // Apply this edge's effects: tags first, then invalidate, write-set, then snoop on new tags.
    task automatic model_update();
        int vi, si;
        vi = int'(bus.vadr_i[12:6]);
        si = int'(bus.snoop_adr[12:6]);
        if (!rst) begin
            for (int w = 0; w < 4; w++) for (int l = 0; l < 128; l++) m_valid[w][l] = 1'b0;
            return;
        end
        if (bus.wr) begin
            m_vtag[bus.way][vi] = bus.vadr_i[31:14];
            m_ptag[bus.way][vi] = bus.padr_i[31:14];
        end
        if (bus.inv) begin
            if (bus.invline) begin
                for (int w = 0; w < 4; w++) m_valid[w][vi] = 1'b0;
            end else if (bus.invall) begin
                for (int w = 0; w < 4; w++) for (int l = 0; l < 128; l++) m_valid[w][l] = 1'b0;
            end
        end
        if (bus.wr) m_valid[bus.way][vi] = 1'b1;
        if (bus.snoop_v) begin
            for (int w = 0; w < 4; w++) if (m_ptag[w][si] == bus.snoop_adr[31:14]) m_valid[w][si] = 1'b0;
        end
    endtask

    task automatic idle();
        bus.wr = 1'b0; bus.way = '0; bus.vadr_i = '0; bus.padr_i = '0;
        bus.inv = 1'b0; bus.invline = 1'b0; bus.invall = 1'b0;
        bus.snoop_v = 1'b0; bus.snoop_adr = '0;
    endtask

    task automatic look(input logic [31:0] a);
        bus.adr = a;
        bus.ndx = a[12:6];
    endtask

    // Called just after a falling edge with inputs set; returns just after the next one.
    task automatic tick();
        #1;
        obs_hit  = bus.hit;
        obs_rway = bus.rway;
        model_lookup(bus.adr, bus.ndx, exp_hit, exp_rway);
        @(posedge clk);
        model_update();
        #1;
        obs_cv = bus.cv;
        exp_cv = rst ? exp_hit : 1'b0;
        @(negedge clk);
        idle();
    endtask

    task automatic write(input int w, input logic [31:0] v, input logic [31:0] p);
        bus.wr = 1'b1; bus.way = 2'(w); bus.vadr_i = v; bus.padr_i = p;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; idle(); look(A);
        tick();
        rst = 1'b1;
        look(A);
        tick();
        total++;
        if (obs_hit !== 1'b0 || obs_rway !== 2'd0) begin
            bad++; $display("FAIL reset_lookup: hit=%b rway=%0d want 0/0", obs_hit, obs_rway);
        end
        total++;
        if (obs_cv !== 1'b0) begin bad++; $display("FAIL reset_cv: cv=%b want 0", obs_cv); end
    endtask

    task automatic test_write();
        look(A);
        write(2, A, P);
        look(A);
        tick();
        total++;
        if (obs_hit !== 1'b1 || obs_rway !== 2'd2) begin
            bad++; $display("FAIL write_hit: hit=%b rway=%0d want 1/2", obs_hit, obs_rway);
        end
        total++;
        if (obs_cv !== 1'b1) begin bad++; $display("FAIL write_cv: cv=%b want 1", obs_cv); end
        look(32'h0000_2140);
        tick();
        total++;
        if (obs_hit !== 1'b0) begin bad++; $display("FAIL tag0_miss: hit=%b want 0", obs_hit); end
    endtask

    task automatic test_invalidate();
        bus.inv = 1'b1; bus.invline = 1'b1; bus.vadr_i = A;
        tick();
        look(A);
        tick();
        total++;
        if (obs_hit !== 1'b0) begin bad++; $display("FAIL invline: hit=%b want 0", obs_hit); end
        write(2, A, P);
        write(0, mk(7, 9), mk(7, 9));
        bus.inv = 1'b1; bus.invall = 1'b1;
        tick();
        look(A);
        tick();
        total++;
        if (obs_hit !== 1'b0) begin bad++; $display("FAIL invall_a: hit=%b want 0", obs_hit); end
        look(mk(7, 9));
        tick();
        total++;
        if (obs_hit !== 1'b0) begin bad++; $display("FAIL invall_b: hit=%b want 0", obs_hit); end
    endtask

    task automatic test_snoop();
        write(2, A, P);
        bus.snoop_v = 1'b1; bus.snoop_adr = P;
        tick();
        look(A);
        tick();
        total++;
        if (obs_hit !== 1'b0) begin bad++; $display("FAIL snoop_clear: hit=%b want 0", obs_hit); end
        write(2, A, P);
        bus.snoop_v = 1'b1; bus.snoop_adr = 32'h8005_2140;
        tick();
        look(A);
        tick();
        total++;
        if (obs_hit !== 1'b1 || obs_rway !== 2'd2) begin
            bad++; $display("FAIL snoop_miss: hit=%b rway=%0d want 1/2", obs_hit, obs_rway);
        end
    endtask

    task automatic test_same_cycle();
        bus.inv = 1'b1; bus.invall = 1'b1;
        tick();
        bus.snoop_v = 1'b1; bus.snoop_adr = P;
        write(1, A, P);
        look(A);
        tick();
        total++;
        if (obs_hit !== 1'b0) begin bad++; $display("FAIL wr_snoop: hit=%b want 0", obs_hit); end
        write(0, mk(7, 9), mk(7, 9));
        bus.inv = 1'b1; bus.invall = 1'b1;
        write(3, A, P);
        look(A);
        tick();
        total++;
        if (obs_hit !== 1'b1 || obs_rway !== 2'd3) begin
            bad++; $display("FAIL wr_invall_kept: hit=%b rway=%0d want 1/3", obs_hit, obs_rway);
        end
        look(mk(7, 9));
        tick();
        total++;
        if (obs_hit !== 1'b0) begin bad++; $display("FAIL wr_invall_other: hit=%b want 0", obs_hit); end
        // Lookup in the write cycle must see the pre-write state.
        look(mk(11, 20));
        write(0, mk(11, 20), mk(11, 20));
        total++;
        if (obs_hit !== 1'b0) begin bad++; $display("FAIL same_cycle_lookup: hit=%b want 0", obs_hit); end
    endtask

    task automatic test_ways();
        bus.inv = 1'b1; bus.invall = 1'b1;
        tick();
        for (int w = 0; w < 4; w++) write(w, mk(w + 1, 5), mk(w + 1, 5));
        look(mk(3, 5));
        tick();
        total++;
        if (obs_hit !== 1'b1 || obs_rway !== 2'd2) begin
            bad++; $display("FAIL way_select: hit=%b rway=%0d want 1/2", obs_hit, obs_rway);
        end
        rst = 1'b0;
        write(0, mk(9, 5), mk(9, 5));
        rst = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            if (t > 4 && t < 9) continue;
            look(mk(t, 5));
            tick();
            total++;
            if (obs_hit !== 1'b0 || obs_rway !== 2'd0) begin
                bad++; $display("FAIL rst_miss_t%0d: hit=%b rway=%0d want 0/0", t, obs_hit, obs_rway);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) != 0);
            bus.wr = 1'($urandom_range(0, 1));
            bus.way = 2'($urandom);
            bus.vadr_i = mk($urandom_range(0, 3), $urandom_range(0, 3)) | 32'($urandom_range(0, 1) << 13);
            bus.padr_i = mk($urandom_range(0, 3), 0) | (bus.vadr_i & 32'h0000_1fc0);
            bus.inv = ($urandom_range(0, 7) == 0);
            bus.invline = 1'($urandom_range(0, 1));
            bus.invall = 1'($urandom_range(0, 1));
            bus.snoop_v = ($urandom_range(0, 5) == 0);
            bus.snoop_adr = mk($urandom_range(0, 3), $urandom_range(0, 3)) | 32'($urandom_range(0, 63));
            look(mk($urandom_range(0, 3), $urandom_range(0, 3)) | 32'($urandom_range(0, 63)));
            tick();
            total++;
            if (obs_hit !== exp_hit || obs_rway !== exp_rway || obs_cv !== exp_cv) begin
                bad++;
                $display("FAIL random_%0d: hit=%b rway=%0d cv=%b want %b/%0d/%b",
                         i, obs_hit, obs_rway, obs_cv, exp_hit, exp_rway, exp_cv);
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        for (int w = 0; w < 4; w++) begin
            for (int l = 0; l < 128; l++) begin
                m_valid[w][l] = 1'b0; m_vtag[w][l] = '0; m_ptag[w][l] = '0;
            end
        end
        idle();
        look('0);
        @(negedge clk);
        test_reset();
        test_write();
        test_invalidate();
        test_snoop();
        test_same_cycle();
        test_ways();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
